// File: rtl/sevenseg_scan_ctrl_if.sv
// iomem bus bundle for the seven-segment scan controller.
// The CPU side drives the request; the peripheral side acknowledges and returns read data.
interface sevenseg_scan_ctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Memory-mapped scan controller for a 4-digit multiplexed seven-segment display.
// The CPU loads four digit bytes and an enable; hardware walks the commons one
// digit per slot, blanking the start of each slot to suppress ghosting, and
// counts completed frames.
// Optional feature: define SEVSEG_HEX_DECODE_EN to make CTRL[1] (HEXMODE)
// writable and add a nibble-to-segment decoder on the pattern path.
module sevenseg_scan_ctrl #(
  parameter logic [7:0] ADDR_BASE    = 8'h04,
  parameter int         DIGIT_CYCLES = 12000,
  parameter int         DEAD_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  sevenseg_scan_ctrl_if.slave   bus,
  output logic [3:0]            COMM,
  output logic [6:0]            SEG
);

  localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [15:0]      frame;
  logic [31:0]      data;
  logic [1:0]       ctrl;

  logic             hit;
  logic [31:0]      rd_sel;
  logic [7:0]       cur_byte;
  logic [6:0]       pattern;
  logic             unused_bits;

`ifdef SEVSEG_HEX_DECODE_EN
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction
`endif

  // Address bits below the word offset and above the register index alias.
  assign unused_bits = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0], bus.iomem_wdata};

  // Request decode: a new, not-yet-acknowledged access to our region.
  always_comb begin
    hit = bus.iomem_valid && !bus.iomem_ready && (bus.iomem_addr[31:24] == ADDR_BASE);
  end

  // Read mux; STATUS reflects pre-edge values so a concurrent frame wrap is not visible.
  always_comb begin
    rd_sel = 32'h0;
    case (bus.iomem_addr[3:2])
      2'd0:    rd_sel = data;
      2'd1:    rd_sel = {30'h0, ctrl};
      2'd2:    rd_sel = {13'h0, (state == DRIVE), digit, frame};
      default: rd_sel = 32'h0;
    endcase
  end

  // Live segment pattern for the digit currently being scanned.
  always_comb begin
    cur_byte = data[{digit, 3'b000} +: 8];
`ifdef SEVSEG_HEX_DECODE_EN
    pattern = ctrl[1] ? hex_decode(cur_byte[3:0]) : cur_byte[6:0];
`else
    pattern = cur_byte[6:0];
`endif
  end

  // Bus slave: one-cycle ack, read data capture and byte-strobed register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= 32'h0;
      data            <= 32'h0;
      ctrl            <= 2'b00;
    end else begin
      bus.iomem_ready <= hit;
      if (hit) begin
        bus.iomem_rdata <= rd_sel;
        if (bus.iomem_addr[3:2] == 2'd0) begin
          for (int i = 0; i < 4; i++) begin
            if (bus.iomem_wstrb[i]) data[i*8 +: 8] <= bus.iomem_wdata[i*8 +: 8];
          end
        end else if (bus.iomem_addr[3:2] == 2'd1 && bus.iomem_wstrb[0]) begin
`ifdef SEVSEG_HEX_DECODE_EN
          ctrl <= bus.iomem_wdata[1:0];
`else
          ctrl <= {1'b0, bus.iomem_wdata[0]};
`endif
        end
      end
    end
  end

  // Scan FSM with registered COMM/SEG derived from the pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      digit <= 2'd0;
      frame <= 16'h0;
      COMM  <= 4'b1111;
      SEG   <= 7'h00;
    end else begin
      if (state == DRIVE && cur_byte[7]) begin
        COMM <= ~(4'b0001 << digit);
        SEG  <= pattern;
      end else begin
        COMM <= 4'b1111;
        SEG  <= 7'h00;
      end

      if (!ctrl[0]) begin
        state <= IDLE;
        cnt   <= '0;
        digit <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            digit <= 2'd0;
          end
          BLANK: begin
            if (cnt == DEAD_LAST) state <= DRIVE;
            cnt <= cnt + 1'b1;
          end
          DRIVE: begin
            if (cnt == SLOT_LAST) begin
              cnt   <= '0;
              digit <= digit + 2'd1;
              if (digit == 2'd3) frame <= frame + 16'd1;
              state <= BLANK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            digit <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
